// File: rtl/uart_rx_word_assembler.sv
// uart_rx_word_assembler
// Receives 8N1 UART frames using 16x oversampling and packs W/8 bytes into
// one W-bit word, least-significant byte first. The finished word is offered
// to the consumer through a word_ready/ack_word handshake.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   RX          serial input, idle high, asynchronous to clk
//   ack_word    consumer accepts data_word (ignored while word_ready=0)
//   data_word   assembled word, stable while word_ready=1
//   word_ready  data_word valid, held until acked
//   frame_err   one-cycle pulse, stop bit sampled low
//   overrun     one-cycle pulse, word completed while previous one unacked
//
// state | meaning
// IDLE  | line idle; waits for rx_s low (and for rx_s high first after a break)
// START | start bit seen; confirm it is still low at mid start bit
// DATA  | sample 8 data bits at mid bit, LSB first
// STOP  | sample stop bit at mid bit; commit byte or flag frame error
module uart_rx_word_assembler #(
   parameter int W        = 32,
   parameter int BAUD_DIV = 326,
   parameter int OVS      = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         RX,
   input  logic         ack_word,
   output logic [W-1:0] data_word,
   output logic         word_ready,
   output logic         frame_err,
   output logic         overrun
);

   localparam int NB = W / 8;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [3:0] S_MID = 4'(OVS / 2 - 1);
   localparam logic [3:0] S_END = 4'(OVS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic            rx_meta, rx_s;
   logic [DW-1:0]   div_cnt;
   logic            tick, div_clr;
   logic [3:0]      s_cnt, s_n;
   logic [2:0]      n_cnt, n_n;
   logic [7:0]      shift_reg, shift_n;
   logic [KW-1:0]   byte_cnt, byte_n;
   logic [W-1:0]    word_acc, acc_n;
   logic            brk, brk_n;
   logic [W-1:0]    data_n;
   logic            ready_n, fe_n, ov_n;

   assign tick = (div_cnt == DW'(BAUD_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         div_cnt    <= '0;
         state      <= IDLE;
         s_cnt      <= '0;
         n_cnt      <= '0;
         shift_reg  <= '0;
         byte_cnt   <= '0;
         word_acc   <= '0;
         brk        <= 1'b0;
         data_word  <= '0;
         word_ready <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_meta    <= RX;
         rx_s       <= rx_meta;
         // restarting the divider on the start edge puts ticks in phase with the frame
         if (div_clr || tick) div_cnt <= '0;
         else                 div_cnt <= div_cnt + 1'b1;
         state      <= state_n;
         s_cnt      <= s_n;
         n_cnt      <= n_n;
         shift_reg  <= shift_n;
         byte_cnt   <= byte_n;
         word_acc   <= acc_n;
         brk        <= brk_n;
         data_word  <= data_n;
         word_ready <= ready_n;
         frame_err  <= fe_n;
         overrun    <= ov_n;
      end
   end

   always_comb begin
      state_n = state;
      s_n     = s_cnt;
      n_n     = n_cnt;
      shift_n = shift_reg;
      byte_n  = byte_cnt;
      acc_n   = word_acc;
      brk_n   = brk;
      data_n  = data_word;
      ready_n = word_ready;
      fe_n    = 1'b0;
      ov_n    = 1'b0;
      div_clr = 1'b0;

      if (word_ready && ack_word) ready_n = 1'b0;

      case (state)
         IDLE: begin
            if (rx_s) begin
               brk_n = 1'b0;
            end else if (!brk) begin
               state_n = START;
               s_n     = '0;
               div_clr = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (s_cnt == S_MID) begin
                  s_n = '0;
                  if (!rx_s) begin
                     state_n = DATA;
                     n_n     = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_n = s_cnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_cnt == S_END) begin
                  shift_n = {rx_s, shift_reg[7:1]};
                  s_n     = '0;
                  if (n_cnt == 3'd7) state_n = STOP;
                  else               n_n     = n_cnt + 3'd1;
               end else begin
                  s_n = s_cnt + 4'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_cnt == S_END) begin
                  state_n = IDLE;
                  s_n     = '0;
                  if (rx_s) begin
                     acc_n[{byte_cnt, 3'b000} +: 8] = shift_reg;
                     if (byte_cnt == KW'(NB - 1)) begin
                        byte_n = '0;
                        // an ack in this same cycle frees the output for the new word
                        if (!word_ready || ack_word) begin
                           data_n  = {shift_reg, word_acc[W-9:0]};
                           ready_n = 1'b1;
                        end else begin
                           ov_n = 1'b1;
                        end
                     end else begin
                        byte_n = byte_cnt + 1'b1;
                     end
                  end else begin
                     // drop the partial word so the next good byte starts a fresh word
                     fe_n   = 1'b1;
                     byte_n = '0;
                     brk_n  = 1'b1;
                  end
               end else begin
                  s_n = s_cnt + 4'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
module tb_uart_rx_word_assembler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1, ack = 1'b0;
   logic        rx64 = 1'b1, ack64 = 1'b0;
   logic [31:0] dw;
   logic        wr, fe, ov;
   logic [63:0] dw64;
   logic        wr64, fe64, ov64;

   always #5 clk = ~clk;

   uart_rx_word_assembler #(.W(32), .BAUD_DIV(4), .OVS(16)) u_dut (
      .clk(clk), .rst(rst), .RX(rx), .ack_word(ack),
      .data_word(dw), .word_ready(wr), .frame_err(fe), .overrun(ov));

   uart_rx_word_assembler #(.W(64), .BAUD_DIV(4), .OVS(16)) u_dut64 (
      .clk(clk), .rst(rst), .RX(rx64), .ack_word(ack64),
      .data_word(dw64), .word_ready(wr64), .frame_err(fe64), .overrun(ov64));

   int n_checks = 0;
   int n_fail   = 0;
   int fe_cnt = 0, ov_cnt = 0, fe64_cnt = 0, ov64_cnt = 0;
   logic [31:0] exp_q[$];
   logic        prev_wr = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
   logic [31:0] prev_dw = '0;

   typedef struct {
      bit          glitch;
      bit          fe_prefix;
      logic [7:0]  b [4];
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [3];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every new word presented is popped against the queue
   initial begin
      forever begin
         @(negedge clk);
         if (fe)   fe_cnt++;
         if (ov)   ov_cnt++;
         if (fe64) fe64_cnt++;
         if (ov64) ov64_cnt++;
         if (fe) check("frame_err_pulse_width", 64'(prev_fe), 64'd0);
         if (ov) check("overrun_pulse_width", 64'(prev_ov), 64'd0);
         if (wr && (!prev_wr || dw !== prev_dw)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got %0h expected none", dw);
            end else begin
               check("word_value", 64'(dw), 64'(exp_q.pop_front()));
            end
         end
         prev_wr = wr;
         prev_dw = dw;
         prev_fe = fe;
         prev_ov = ov;
      end
   end

   // all stimulus tasks start and end #1 after a rising edge
   task automatic drive_bits(input bit sel, input logic v, input int n);
      if (sel) rx64 = v;
      else     rx   = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // returns #1 after the edge that ends the mid-stop-bit sample cycle's predecessor,
   // i.e. while the DUT is in the stop-sample cycle
   task automatic send_head(input logic [7:0] d, input logic stop, input bit sel);
      drive_bits(sel, 1'b0, 64);
      for (int i = 0; i < 8; i++) drive_bits(sel, d[i], 64);
      drive_bits(sel, stop, 34);
   endtask

   task automatic send_tail(input bit sel, input int n);
      repeat (n) @(posedge clk);
      #1;
      drive_bits(sel, 1'b1, 8);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop, input bit sel);
      send_head(d, stop, sel);
      send_tail(sel, 30);
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
   endtask

   int fe0, ov0;

   initial begin
      vecs[0].glitch = 1'b0; vecs[0].fe_prefix = 1'b0;
      vecs[0].b = '{8'h78, 8'h56, 8'h34, 8'h12}; vecs[0].exp = 32'h12345678;
      vecs[1].glitch = 1'b1; vecs[1].fe_prefix = 1'b0;
      vecs[1].b = '{8'hA5, 8'hC3, 8'h0F, 8'hF0}; vecs[1].exp = 32'hF00FC3A5;
      vecs[2].glitch = 1'b0; vecs[2].fe_prefix = 1'b1;
      vecs[2].b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; vecs[2].exp = 32'hDDCCBBAA;

      repeat (3) @(posedge clk);
      #1;
      check("reset_data_word", 64'(dw), 64'd0);
      check("reset_word_ready", 64'(wr), 64'd0);
      check("reset_frame_err", 64'(fe), 64'd0);
      check("reset_overrun", 64'(ov), 64'd0);
      check("reset_word_ready_w64", 64'(wr64), 64'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      pulse_ack();
      check("ack_while_idle_ignored", 64'(wr), 64'd0);

      for (int v = 0; v < 3; v++) begin
         fe0 = fe_cnt;
         ov0 = ov_cnt;
         if (vecs[v].glitch) begin
            rx = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            rx = 1'b1;
            repeat (60) @(posedge clk);
            #1;
            check("glitch_no_frame_err", 64'(fe_cnt - fe0), 64'd0);
            check("glitch_no_ready", 64'(wr), 64'd0);
         end
         if (vecs[v].fe_prefix) begin
            send_byte(8'h11, 1'b1, 1'b0);
            send_byte(8'h22, 1'b0, 1'b0);
            check("frame_err_count", 64'(fe_cnt - fe0), 64'd1);
            check("frame_err_no_ready", 64'(wr), 64'd0);
         end
         exp_q.push_back(vecs[v].exp);
         for (int k = 0; k < 3; k++) send_byte(vecs[v].b[k], 1'b1, 1'b0);
         send_head(vecs[v].b[3], 1'b1, 1'b0);
         check("ready_not_early", 64'(wr), 64'd0);
         @(posedge clk);
         #1;
         check("ready_latency", 64'(wr), 64'd1);
         check("vec_data_word", 64'(dw), 64'(vecs[v].exp));
         send_tail(1'b0, 29);
         check("vec_queue_drained", 64'(exp_q.size()), 64'd0);
         pulse_ack();
         check("ack_drops_ready", 64'(wr), 64'd0);
         check("vec_no_overrun", 64'(ov_cnt - ov0), 64'd0);
      end

      // overrun: second word arrives while the first is still unacked
      exp_q.push_back(32'h01020304);
      send_byte(8'h04, 1'b1, 1'b0);
      send_byte(8'h03, 1'b1, 1'b0);
      send_byte(8'h02, 1'b1, 1'b0);
      send_byte(8'h01, 1'b1, 1'b0);
      check("overrun_first_ready", 64'(wr), 64'd1);
      ov0 = ov_cnt;
      send_byte(8'h08, 1'b1, 1'b0);
      send_byte(8'h07, 1'b1, 1'b0);
      send_byte(8'h06, 1'b1, 1'b0);
      send_byte(8'h05, 1'b1, 1'b0);
      check("overrun_count", 64'(ov_cnt - ov0), 64'd1);
      check("overrun_ready_held", 64'(wr), 64'd1);
      check("overrun_data_kept", 64'(dw), 64'h01020304);
      pulse_ack();
      check("overrun_ack_drop", 64'(wr), 64'd0);

      // ack in the exact completion cycle of the next word
      exp_q.push_back(32'h0BADBEEF);
      send_byte(8'hEF, 1'b1, 1'b0);
      send_byte(8'hBE, 1'b1, 1'b0);
      send_byte(8'hAD, 1'b1, 1'b0);
      send_byte(8'h0B, 1'b1, 1'b0);
      exp_q.push_back(32'hCAFEF00D);
      ov0 = ov_cnt;
      send_byte(8'h0D, 1'b1, 1'b0);
      send_byte(8'hF0, 1'b1, 1'b0);
      send_byte(8'hFE, 1'b1, 1'b0);
      send_head(8'hCA, 1'b1, 1'b0);
      pulse_ack();
      check("same_cycle_ack_ready", 64'(wr), 64'd1);
      check("same_cycle_ack_data", 64'(dw), 64'hCAFEF00D);
      send_tail(1'b0, 29);
      check("same_cycle_ack_no_overrun", 64'(ov_cnt - ov0), 64'd0);
      check("same_cycle_queue_drained", 64'(exp_q.size()), 64'd0);

      // reset in the data bits of the third byte, word_ready still high
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_byte(8'h99, 1'b1, 1'b0);
      send_byte(8'h88, 1'b1, 1'b0);
      drive_bits(1'b0, 1'b0, 64);
      drive_bits(1'b0, 1'b0, 64 * 3);
      rst = 1'b1;
      rx  = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midframe_rst_data_word", 64'(dw), 64'd0);
      check("midframe_rst_word_ready", 64'(wr), 64'd0);
      check("midframe_rst_frame_err", 64'(fe), 64'd0);
      check("midframe_rst_overrun", 64'(ov), 64'd0);
      repeat (20) @(posedge clk);
      #1;
      check("midframe_rst_no_pulses", 64'((fe_cnt - fe0) + (ov_cnt - ov0)), 64'd0);
      exp_q.push_back(32'h11223344);
      send_byte(8'h44, 1'b1, 1'b0);
      send_byte(8'h33, 1'b1, 1'b0);
      send_byte(8'h22, 1'b1, 1'b0);
      send_byte(8'h11, 1'b1, 1'b0);
      check("post_rst_word", 64'(dw), 64'h11223344);
      check("post_rst_ready", 64'(wr), 64'd1);
      pulse_ack();

      // 64-bit instance, eight bytes
      for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b1, 1'b1);
      check("w64_ready", 64'(wr64), 64'd1);
      check("w64_data_word", dw64, 64'h0807060504030201);
      check("w64_no_pulses", 64'(fe64_cnt + ov64_cnt), 64'd0);

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_word_assembler.md
Name: uart_rx_word_assembler

Overview:
- UART receive path that feeds operands into the FPU/CORDIC test harness.
- Deserialises 8N1 frames on RX with 16x oversampling.
- Packs W/8 consecutive bytes, least-significant byte first, into one W-bit word. This is the same byte order the transmit side uses.
- Presents the word to the consumer with a ready/ack handshake.

Parameters:
- W, 32: word width in bits; legal values 32 or 64; must be a multiple of 8.
- BAUD_DIV, 326: clk cycles per oversample tick. The default is 100 MHz / (19200 x 16), rounded.
- OVS, 16: oversample ticks per bit; fixed at 16.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- RX  in  1  serial input, idle high, asynchronous to clk
- ack_word  in  1  consumer accepts data_word; sampled only while word_ready=1
- data_word  out  W  assembled word
- word_ready  out  1  data_word valid; held until acked
- frame_err  out  1  one-cycle pulse, stop bit sampled low
- overrun  out  1  one-cycle pulse, a word completed while the previous one was unacked

Behaviour:
- Reset values (synchronous, on rst=1 at a clk edge):
  - Outputs: data_word=0, word_ready=0, frame_err=0, overrun=0.
  - Internal: synchroniser flops=1, FSM=IDLE, byte counter=0, shift register=0, tick counter=0.
  - Reset mid-frame or mid-word aborts everything and discards the partial word. No pulses are generated.
- RX synchroniser: 2 flops. All logic uses the synchronised signal rx_s.
- Tick generator: counts 0..BAUD_DIV-1 and emits a one-cycle tick at terminal count. It is forced to 0 on the cycle a start edge is detected, for phase alignment.
- FSM states: IDLE, START, DATA, STOP. A 4-bit tick counter s and a 3-bit bit counter n run within the states.
- IDLE:
  - Stay while rx_s=1.
  - On the first clk with rx_s=0, go to START with s=0.
- START:
  - At tick with s=7 (mid start bit): if rx_s=0, go to DATA with s=0, n=0.
  - If rx_s=1 at that point, treat it as a glitch and return to IDLE. No pulses.
- DATA:
  - At tick with s=15, sample rx_s into the shift register MSB, shifting right (LSB received first). Then clear s.
  - After n=7 is sampled, go to STOP.
- STOP, at tick with s=15:
  - rx_s=1: the byte is good. Write it to word bits [8k+7:8k] with k = byte counter, increment k, go to IDLE.
  - rx_s=0: pulse frame_err for 1 clk, discard the byte, clear k to 0 (the partial word is dropped to resync), go to IDLE.
- Word completion (good stop on byte k = W/8-1), next clk:
  - If word_ready=0, or ack_word=1 in the completion cycle: load data_word, set word_ready=1, set k=0.
  - If word_ready=1 and ack_word=0: keep data_word, pulse overrun, drop the new word, set k=0.
- Handshake:
  - word_ready falls on the clk after ack_word=1 is sampled, unless a new word loads in that same cycle, in which case it stays 1.
  - ack_word while word_ready=0 is ignored.
  - data_word is stable whenever word_ready=1.
- Latency: word_ready rises 1 clk after the mid-stop-bit sample of the last byte.
- Break condition: RX held low through a whole frame is a frame error. The FSM then waits in IDLE for rx_s=1 before re-arming, so a continuous low does not retrigger.

Test Plan (bench uses BAUD_DIV=4, so 1 bit = 64 clk):
- Word assembly: send bytes 0x78, 0x56, 0x34, 0x12 at nominal baud -> word_ready=1 and data_word=0x12345678 one clk after the 4th stop mid-sample; ack_word pulse -> word_ready=0 on the next clk.
- Glitch rejection: RX low for 20 clk, then high -> no state change, no pulses; a following byte 0xA5 is received correctly as byte 0.
- Frame error resync: send 0x11 good, then 0x22 with stop=0 -> frame_err single pulse and k reset; then 0xAA, 0xBB, 0xCC, 0xDD -> data_word=0xDDCCBBAA.
- Overrun: complete word 0x01020304 without ack, then send 0x05060708 -> overrun single pulse, data_word stays 0x01020304, word_ready stays 1.
- Same-cycle ack: assert ack_word in the exact completion cycle of the second word 0xCAFEF00D -> data_word=0xCAFEF00D, word_ready stays 1, no overrun.
- Reset mid-frame: rst during the DATA bits of byte 3 -> all outputs 0 on the next clk; next 4 bytes 0x44, 0x33, 0x22, 0x11 -> 0x11223344. Also run the 0x12345678 case at W=64 using 8 bytes 0x01..0x08 -> 0x0807060504030201.
